// File: rtl/exec_result_pipe_pkg.sv
// -----------------------------------------------------------------------------
// exec_result_pipe_pkg
// Shared definitions for the execution result pipe: default widths, execution
// unit identifiers, packet field offsets and small helper functions.
// Packet layout, MSB first: {unit_id, result, reg_dst, latency, reg_wr}.
// -----------------------------------------------------------------------------
package exec_result_pipe_pkg;

   localparam int DEF_DATA_W      = 128;
   localparam int DEF_DEPTH       = 6;
   localparam int DEF_FLUSH_DEPTH = 2;
   localparam int DEF_UNIT_W      = 3;
   localparam int DEF_REG_W       = 7;
   localparam int DEF_LAT_W       = 4;

   typedef enum logic [2:0] {
      UNIT_PERM   = 3'b101,
      UNIT_LS     = 3'b110,
      UNIT_BRANCH = 3'b111
   } unit_e;

   // Field offsets, counted from the packet LSB.
   localparam int REG_WR_OFS = 0;
   localparam int LAT_OFS    = 1;

   function automatic int reg_dst_ofs(input int lat_w);
      return LAT_OFS + lat_w;
   endfunction

   function automatic int result_ofs(input int reg_w, input int lat_w);
      return reg_dst_ofs(lat_w) + reg_w;
   endfunction

   function automatic int unit_ofs(input int data_w, input int reg_w, input int lat_w);
      return result_ofs(reg_w, lat_w) + data_w;
   endfunction

   function automatic int pkt_width(input int unit_w, input int data_w,
                                    input int reg_w, input int lat_w);
      return unit_ofs(data_w, reg_w, lat_w) + unit_w;
   endfunction

   // A latency of 0, or one longer than the pipe, means "final only at the
   // last stage".
   function automatic int eff_latency(input int lat, input int depth);
      return (lat == 0 || lat > depth) ? depth : lat;
   endfunction

endpackage

// File: rtl/exec_result_pipe_stage.sv
// -----------------------------------------------------------------------------
// pipe_stage
// One result-pipe register holding a packet and its valid bit.
// Priority: reset > clear > load > hold.
//   clk, rst   : clock, synchronous active-low reset
//   load       : capture pkt_d / valid_d
//   clear      : zero packet and valid
//   pkt_d      : next packet
//   valid_d    : next valid
//   pkt, valid : registered stage contents
// -----------------------------------------------------------------------------
module pipe_stage #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         clear,
   input  logic [W-1:0] pkt_d,
   input  logic         valid_d,
   output logic [W-1:0] pkt,
   output logic         valid
);

   // NOTE: state registers use non-blocking assignment so every stage samples
   // its neighbour's pre-edge value; blocking here would ripple data through
   // the whole pipe in a single clock.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pkt   <= '0;
         valid <= 1'b0;
      end else if (clear) begin
         pkt   <= '0;
         valid <= 1'b0;
      end else if (load) begin
         pkt   <= pkt_d;
         valid <= valid_d;
      end
   end

endmodule

// File: rtl/exec_result_pipe.sv
// -----------------------------------------------------------------------------
// exec_result_pipe
// Fixed-depth shift pipe that carries execution results to a registered
// writeback port, with stall (hold), flush (squash young stages) and
// per-stage forwarding-ready flags. Pure buffering and control.
//   clk, rst      : clock, synchronous active-low reset
//   stall, flush  : hold all stages / clear the FLUSH_DEPTH youngest stages
//   in_*          : packet issued this cycle when in_valid=1
//   stage_pkt     : all stage packets, stage 1 in the MSB slice
//   stage_valid   : occupancy per stage, bit k-1 is stage k
//   fwd_ready     : stage result final and forwardable, bit k-1 is stage k
//   wb_en/addr/data : registered writeback taken from the last stage
//   occupancy     : registered count of valid stages
// -----------------------------------------------------------------------------
module exec_result_pipe
   import exec_result_pipe_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int DEPTH       = DEF_DEPTH,
   parameter int FLUSH_DEPTH = DEF_FLUSH_DEPTH,
   parameter int UNIT_W      = DEF_UNIT_W,
   parameter int REG_W       = DEF_REG_W,
   parameter int LAT_W       = DEF_LAT_W,
   parameter int PKT_W       = UNIT_W + DATA_W + REG_W + LAT_W + 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       stall,
   input  logic                       flush,
   input  logic                       in_valid,
   input  logic [UNIT_W-1:0]          in_unit_id,
   input  logic [DATA_W-1:0]          in_result,
   input  logic [REG_W-1:0]           in_reg_dst,
   input  logic [LAT_W-1:0]           in_latency,
   input  logic                       in_reg_wr,
   output logic [DEPTH*PKT_W-1:0]     stage_pkt,
   output logic [DEPTH-1:0]           stage_valid,
   output logic [DEPTH-1:0]           fwd_ready,
   output logic                       wb_en,
   output logic [REG_W-1:0]           wb_addr,
   output logic [DATA_W-1:0]          wb_data,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int OCC_W       = $clog2(DEPTH + 1);
   localparam int REG_DST_OFS = reg_dst_ofs(LAT_W);
   localparam int RESULT_OFS  = result_ofs(REG_W, LAT_W);

   logic [PKT_W-1:0] pkt_q  [DEPTH];
   logic [PKT_W-1:0] pkt_d  [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] valid_d;
   logic [DEPTH-1:0] load;
   logic [DEPTH-1:0] clear;
   logic [DEPTH-1:0] next_valid;
   logic [PKT_W-1:0] pkt_in;

   assign pkt_in = {in_unit_id, in_result, in_reg_dst, in_latency, in_reg_wr};

   function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH-1:0] v);
      logic [OCC_W-1:0] n;
      n = '0;
      for (int i = 0; i < DEPTH; i++) n = n + OCC_W'(v[i]);
      return n;
   endfunction

   // Per-stage control. The stage just past the flush window receives the
   // bubble (clear) when shifting, but holds its packet if also stalled.
   // NOTE: every signal written here gets a value on every path, starting with
   // these defaults, so no latch is inferred.
   always_comb begin
      pkt_d      = '{default: '0};
      valid_d    = '0;
      load       = '0;
      clear      = '0;
      next_valid = '0;
      pkt_d[0]   = in_valid ? pkt_in : '0;
      valid_d[0] = in_valid;
      for (int k = 1; k < DEPTH; k++) begin
         pkt_d[k]   = pkt_q[k-1];
         valid_d[k] = valid_q[k-1];
      end
      for (int k = 0; k < DEPTH; k++) begin
         load[k]  = !stall;
         clear[k] = flush && (k < FLUSH_DEPTH || (k == FLUSH_DEPTH && !stall));
         next_valid[k] = clear[k] ? 1'b0 : (load[k] ? valid_d[k] : valid_q[k]);
      end
   end

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      pipe_stage #(.W(PKT_W)) u_stage (
         .clk     (clk),
         .rst     (rst),
         .load    (load[k]),
         .clear   (clear[k]),
         .pkt_d   (pkt_d[k]),
         .valid_d (valid_d[k]),
         .pkt     (pkt_q[k]),
         .valid   (valid_q[k])
      );
      assign stage_pkt[(DEPTH-k)*PKT_W-1 -: PKT_W] = pkt_q[k];
   end

   assign stage_valid = valid_q;

   // Stage k+1 (1-based) is final once it has spent at least 'latency' stages.
   always_comb begin
      fwd_ready = '0;
      for (int k = 0; k < DEPTH; k++) begin
         fwd_ready[k] = valid_q[k] && pkt_q[k][REG_WR_OFS] &&
                        ((k + 1) >= eff_latency(int'(pkt_q[k][LAT_OFS +: LAT_W]), DEPTH));
      end
   end

   // Writeback registers the packet leaving the last stage; nothing leaves
   // while stalled, so wb_en drops and the address/data hold.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wb_en   <= 1'b0;
         wb_addr <= '0;
         wb_data <= '0;
      end else if (stall) begin
         wb_en   <= 1'b0;
      end else begin
         wb_en   <= valid_q[DEPTH-1] && pkt_q[DEPTH-1][REG_WR_OFS];
         wb_addr <= pkt_q[DEPTH-1][REG_DST_OFS +: REG_W];
         wb_data <= pkt_q[DEPTH-1][RESULT_OFS +: DATA_W];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) occupancy <= '0;
      else      occupancy <= popcount(next_valid);
   end

endmodule

// File: tb/tb_exec_result_pipe.sv
// -----------------------------------------------------------------------------
// tb_exec_result_pipe
// Directed bench for exec_result_pipe at default parameters. Inputs change
// 1 ns after the rising edge; outputs are checked at that same point.
// -----------------------------------------------------------------------------
module tb_exec_result_pipe;

   localparam int DATA_W = 128;
   localparam int DEPTH  = 6;
   localparam int UNIT_W = 3;
   localparam int REG_W  = 7;
   localparam int LAT_W  = 4;
   localparam int PKT_W  = UNIT_W + DATA_W + REG_W + LAT_W + 1;

   typedef logic [255:0] val_t;

   logic                   clk = 1'b0;
   logic                   rst, stall, flush, in_valid, in_reg_wr;
   logic [UNIT_W-1:0]      in_unit_id;
   logic [DATA_W-1:0]      in_result;
   logic [REG_W-1:0]       in_reg_dst;
   logic [LAT_W-1:0]       in_latency;
   logic [DEPTH*PKT_W-1:0] stage_pkt;
   logic [DEPTH-1:0]       stage_valid, fwd_ready;
   logic                   wb_en;
   logic [REG_W-1:0]       wb_addr;
   logic [DATA_W-1:0]      wb_data;
   logic [2:0]             occupancy;

   int n_checks = 0;
   int n_fail   = 0;
   logic [REG_W-1:0] wb_q [$];

   always #5 clk = ~clk;

   exec_result_pipe dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_unit_id  (in_unit_id),
      .in_result   (in_result),
      .in_reg_dst  (in_reg_dst),
      .in_latency  (in_latency),
      .in_reg_wr   (in_reg_wr),
      .stage_pkt   (stage_pkt),
      .stage_valid (stage_valid),
      .fwd_ready   (fwd_ready),
      .wb_en       (wb_en),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .occupancy   (occupancy)
   );

   task automatic check(input string tag, input val_t got, input val_t exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] res_of(input logic [REG_W-1:0] dst);
      return {16{{1'b0, dst}}};
   endfunction

   function automatic logic [PKT_W-1:0] mk(input logic [REG_W-1:0] dst,
                                           input logic [LAT_W-1:0] lat, input logic wr);
      return {3'b110, res_of(dst), dst, lat, wr};
   endfunction

   function automatic logic [PKT_W-1:0] stage(input int k);
      return stage_pkt[(DEPTH-k+1)*PKT_W-1 -: PKT_W];
   endfunction

   task automatic drive(input logic v, input logic [REG_W-1:0] dst,
                        input logic [LAT_W-1:0] lat, input logic wr);
      in_valid   = v;
      in_unit_id = v ? 3'b110 : 3'b000;
      in_reg_dst = dst;
      in_result  = res_of(dst);
      in_latency = lat;
      in_reg_wr  = wr;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (wb_en) wb_q.push_back(wb_addr);
   endtask

   task automatic idle(input int n);
      drive(1'b0, '0, '0, 1'b0);
      repeat (n) step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; stall = 1'b0; flush = 1'b0;
      drive(1'b0, '0, '0, 1'b0);
      repeat (2) step();
      check("rst_valid", val_t'(stage_valid), val_t'(0));
      check("rst_occ",   val_t'(occupancy),   val_t'(0));
      check("rst_wb_en", val_t'(wb_en),       val_t'(0));
      check("rst_pkt",   val_t'(|stage_pkt),  val_t'(0));
      rst = 1'b1;

      // Single issue: writeback on the 7th edge counting the issue edge.
      drive(1'b1, 7'd5, 4'd2, 1'b1);
      step();
      check("s1_valid", val_t'(stage_valid), val_t'(6'b000001));
      check("s1_pkt",   val_t'(stage(1)),    val_t'(mk(7'd5, 4'd2, 1'b1)));
      check("s1_fwd",   val_t'(fwd_ready),   val_t'(0));
      drive(1'b0, '0, '0, 1'b0);
      for (int t = 2; t <= 7; t++) begin
         step();
         if (t <= 6) check($sformatf("s1_fwd_t%0d", t), val_t'(fwd_ready), val_t'(6'b1 << (t-1)));
         check($sformatf("s1_wb_en_t%0d", t), val_t'(wb_en), val_t'(t == 7));
      end
      check("s1_wb_addr", val_t'(wb_addr), val_t'(7'd5));
      check("s1_wb_data", val_t'(wb_data), val_t'({16{8'hA5}} & 128'h0) | val_t'(res_of(7'd5)));
      step();
      check("s1_wb_off", val_t'(wb_en),     val_t'(0));
      check("s1_occ",    val_t'(occupancy), val_t'(0));

      // Back-to-back issue: occupancy saturates, writeback in issue order.
      wb_q.delete();
      for (int j = 1; j <= 8; j++) begin
         drive(1'b1, 7'(9 + j), 4'd1, 1'b1);
         step();
         check($sformatf("b2b_occ_%0d", j), val_t'(occupancy), val_t'(j < 6 ? j : 6));
      end
      idle(10);
      check("b2b_wb_cnt", val_t'(wb_q.size()), val_t'(8));
      for (int j = 0; j < 8 && j < wb_q.size(); j++)
         check($sformatf("b2b_wb_%0d", j), val_t'(wb_q[j]), val_t'(10 + j));

      // Stall with a full pipe: hold, no writeback, issues dropped.
      for (int j = 0; j < 6; j++) begin
         drive(1'b1, 7'(20 + j), 4'd2, 1'b1);
         step();
      end
      stall = 1'b1;
      drive(1'b1, 7'd99, 4'd2, 1'b1);
      for (int j = 0; j < 3; j++) begin
         step();
         check("stl_valid", val_t'(stage_valid), val_t'(6'h3F));
         check("stl_wb_en", val_t'(wb_en),       val_t'(0));
         check("stl_s1",    val_t'(stage(1)),    val_t'(mk(7'd25, 4'd2, 1'b1)));
         check("stl_s6",    val_t'(stage(6)),    val_t'(mk(7'd20, 4'd2, 1'b1)));
         check("stl_occ",   val_t'(occupancy),   val_t'(6));
      end
      stall = 1'b0;
      wb_q.delete();
      idle(7);
      check("stl_wb_cnt", val_t'(wb_q.size()), val_t'(6));
      for (int j = 0; j < 6 && j < wb_q.size(); j++)
         check($sformatf("stl_wb_%0d", j), val_t'(wb_q[j]), val_t'(20 + j));

      // Flush with stages 1..4 valid.
      for (int j = 0; j < 4; j++) begin
         drive(1'b1, 7'(30 + j), 4'd2, 1'b1);
         step();
      end
      check("fl_occ_pre", val_t'(occupancy), val_t'(4));
      flush = 1'b1;
      drive(1'b1, 7'd77, 4'd2, 1'b1);
      step();
      flush = 1'b0;
      check("fl_valid", val_t'(stage_valid), val_t'(6'b011000));
      check("fl_occ",   val_t'(occupancy),   val_t'(2));
      check("fl_s1",    val_t'(stage(1)),    val_t'(0));
      check("fl_s3",    val_t'(stage(3)),    val_t'(0));
      check("fl_s4",    val_t'(stage(4)),    val_t'(mk(7'd31, 4'd2, 1'b1)));
      check("fl_s5",    val_t'(stage(5)),    val_t'(mk(7'd30, 4'd2, 1'b1)));
      idle(8);

      // Flush and stall together with a full pipe.
      for (int j = 0; j < 6; j++) begin
         drive(1'b1, 7'(40 + j), 4'd2, 1'b1);
         step();
      end
      flush = 1'b1; stall = 1'b1;
      drive(1'b1, 7'd88, 4'd2, 1'b1);
      step();
      flush = 1'b0; stall = 1'b0;
      check("fs_valid", val_t'(stage_valid), val_t'(6'b111100));
      check("fs_occ",   val_t'(occupancy),   val_t'(4));
      check("fs_wb_en", val_t'(wb_en),       val_t'(0));
      check("fs_s1",    val_t'(stage(1)),    val_t'(0));
      check("fs_s3",    val_t'(stage(3)),    val_t'(mk(7'd43, 4'd2, 1'b1)));
      check("fs_s6",    val_t'(stage(6)),    val_t'(mk(7'd40, 4'd2, 1'b1)));
      idle(8);

      // Latency 0 / over-depth forward only at the last stage; reg_wr=0 never.
      wb_q.delete();
      for (int t = 1; t <= 9; t++) begin
         case (t)
            1:       drive(1'b1, 7'd50, 4'd0, 1'b1);
            2:       drive(1'b1, 7'd51, 4'd1, 1'b0);
            3:       drive(1'b1, 7'd52, 4'd9, 1'b1);
            default: drive(1'b0, '0, '0, 1'b0);
         endcase
         step();
         check($sformatf("lat_fwd_t%0d", t), val_t'(fwd_ready),
               val_t'((t == 6 || t == 8) ? 6'b100000 : 6'b000000));
      end
      check("lat_wb_cnt", val_t'(wb_q.size()), val_t'(2));
      if (wb_q.size() == 2) begin
         check("lat_wb_0", val_t'(wb_q[0]), val_t'(50));
         check("lat_wb_1", val_t'(wb_q[1]), val_t'(52));
      end

      // Reset mid-stream beats flush and stall.
      for (int j = 0; j < 5; j++) begin
         drive(1'b1, 7'(60 + j), 4'd2, 1'b1);
         step();
      end
      check("mr_valid_pre", val_t'(stage_valid), val_t'(6'b011111));
      rst = 1'b0; flush = 1'b1; stall = 1'b1;
      step();
      check("mr_valid",   val_t'(stage_valid), val_t'(0));
      check("mr_occ",     val_t'(occupancy),   val_t'(0));
      check("mr_pkt",     val_t'(|stage_pkt),  val_t'(0));
      check("mr_wb_en",   val_t'(wb_en),       val_t'(0));
      check("mr_wb_addr", val_t'(wb_addr),     val_t'(0));
      check("mr_wb_data", val_t'(wb_data),     val_t'(0));
      rst = 1'b1; flush = 1'b0; stall = 1'b0;
      wb_q.delete();
      idle(8);
      check("mr_no_wb", val_t'(wb_q.size()), val_t'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
